// File: rtl/csi2_rx_pkg.sv
// Shared CSI-2 receive definitions: lane aligner states and the HS sync byte.
package csi2_rx_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned SLIP_POS_W   = 3;
  localparam int unsigned ALIGN_ST_W   = 3;

  // HS leader sync byte as presented LSB-first by the deserializer.
  localparam logic [BYTE_W-1:0] DPHY_SYNC_BYTE = 8'hB8;

  typedef enum logic [ALIGN_ST_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_SLIP    = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_WAIT_LP = 3'd5
  } align_state_e;

endpackage

// File: rtl/dphy_byte_align_ctrl.sv
// Per-lane D-PHY byte aligner: hunts for the HS sync byte after SoT and issues at
// most one deserializer bitslip per failed burst, flagging persistent misalignment.
module dphy_byte_align_ctrl
  import csi2_rx_pkg::*;
#(
  parameter logic [BYTE_W-1:0] SYNC_BYTE     = DPHY_SYNC_BYTE,
  parameter int unsigned       SEARCH_WINDOW = 16,
  parameter int unsigned       SETTLE_CYCLES = 3,
  parameter int unsigned       MAX_MISSES    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  hs_active_i,
  input  logic [BYTE_W-1:0]     byte_i,
  output logic                  bitslip_o,
  output logic                  aligned_o,
  output logic                  sync_det_o,
  output logic [SLIP_POS_W-1:0] slip_pos_o,
  output logic                  align_err_o
);

  localparam int unsigned WIN_W  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned MISS_W = (MAX_MISSES > 0) ? $clog2(MAX_MISSES + 1) : 1;

  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MAX_MISSES);

  align_state_e          state_q, state_d;
  logic                  hs_prev_q;
  logic [WIN_W-1:0]      win_q, win_d;
  logic [SET_W-1:0]      settle_q, settle_d;
  logic [MISS_W-1:0]     miss_q, miss_d;
  logic [SLIP_POS_W-1:0] slip_pos_d;
  logic                  bitslip_d;
  logic                  sync_det_d;
  logic                  aligned_d;
  logic                  align_err_d;
  logic                  hs_rise;

  // hs_prev_q resets high so a lane already in HS at reset release is ignored
  // until it goes back to LP and starts a fresh burst.
  assign hs_rise = hs_active_i & ~hs_prev_q;

  // Next-state and next-output decode.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    settle_d    = settle_q;
    miss_d      = miss_q;
    slip_pos_d  = slip_pos_o;
    align_err_d = align_err_o;
    bitslip_d   = 1'b0;
    sync_det_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hs_rise) begin
          state_d = ST_SEARCH;
          win_d   = '0;
        end
      end

      ST_SEARCH: begin
        if (!hs_active_i) begin
          state_d = ST_IDLE;
        end else if (byte_i == SYNC_BYTE) begin
          state_d     = ST_LOCKED;
          sync_det_d  = 1'b1;
          miss_d      = '0;
          align_err_d = 1'b0;
        end else if (win_q == WIN_LAST) begin
          state_d    = ST_SLIP;
          bitslip_d  = 1'b1;
          slip_pos_d = slip_pos_o + SLIP_POS_W'(1);
          if (miss_q != MISS_MAX) begin
            miss_d = miss_q + MISS_W'(1);
          end
          if (miss_d == MISS_MAX) begin
            align_err_d = 1'b1;
          end
        end else begin
          win_d = win_q + WIN_W'(1);
        end
      end

      ST_SLIP: begin
        settle_d = '0;
        state_d  = (SETTLE_CYCLES == 0) ? ST_WAIT_LP : ST_SETTLE;
      end

      // The settle runs to completion even if the burst ends underneath it.
      ST_SETTLE: begin
        if (settle_q == SET_LAST) begin
          state_d = ST_WAIT_LP;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end

      ST_LOCKED: begin
        if (!hs_active_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT_LP: begin
        if (!hs_active_i) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    aligned_d = (state_d == ST_LOCKED);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      hs_prev_q   <= 1'b1;
      win_q       <= '0;
      settle_q    <= '0;
      miss_q      <= '0;
      bitslip_o   <= 1'b0;
      aligned_o   <= 1'b0;
      sync_det_o  <= 1'b0;
      slip_pos_o  <= '0;
      align_err_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      hs_prev_q   <= hs_active_i;
      win_q       <= win_d;
      settle_q    <= settle_d;
      miss_q      <= miss_d;
      bitslip_o   <= bitslip_d;
      aligned_o   <= aligned_d;
      sync_det_o  <= sync_det_d;
      slip_pos_o  <= slip_pos_d;
      align_err_o <= align_err_d;
    end
  end

endmodule

// File: tb/tb_dphy_byte_align_ctrl.sv
// Directed bench for dphy_byte_align_ctrl: per-cycle expected outputs are queued
// as each cycle is driven and compared against the DUT on the falling edge.
module tb_dphy_byte_align_ctrl;

  localparam int unsigned SW   = 16;
  localparam int unsigned MM   = 8;
  localparam logic [7:0]  SYNC = 8'hB8;

  typedef struct packed {
    logic       bitslip;
    logic       sync_det;
    logic       aligned;
    logic [2:0] slip_pos;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       hs_active;
  logic [7:0] lane_byte;
  logic       bitslip;
  logic       aligned;
  logic       sync_det;
  logic [2:0] slip_pos;
  logic       align_err;

  exp_t exp_q[$];
  exp_t mon_e;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  // Spec-level model of the state visible across bursts.
  int unsigned pos_m  = 0;
  int unsigned miss_m = 0;
  bit          err_m  = 1'b0;

  dphy_byte_align_ctrl dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .hs_active_i (hs_active),
    .byte_i      (lane_byte),
    .bitslip_o   (bitslip),
    .aligned_o   (aligned),
    .sync_det_o  (sync_det),
    .slip_pos_o  (slip_pos),
    .align_err_o (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [7:0] rand_nonsync();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == SYNC) b = 8'hB9;
    return b;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.bitslip  = 1'b0;
    e.sync_det = 1'b0;
    e.aligned  = 1'b0;
    e.slip_pos = 3'(pos_m);
    e.err      = err_m;
    return e;
  endfunction

  // Scoreboard consumer: one expected entry per driven cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("bitslip",  8'(bitslip),   8'(mon_e.bitslip));
      check("sync_det", 8'(sync_det),  8'(mon_e.sync_det));
      check("aligned",  8'(aligned),   8'(mon_e.aligned));
      check("slip_pos", 8'(slip_pos),  8'(mon_e.slip_pos));
      check("align_err", 8'(align_err), 8'(mon_e.err));
    end
  end

  task automatic drive_cycle(input logic hs, input logic [7:0] b, input exp_t e);
    @(posedge clk);
    #1;
    hs_active = hs;
    lane_byte = b;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic hs);
    for (int i = 0; i < n; i++) drive_cycle(hs, rand_nonsync(), idle_exp());
  endtask

  // Cycle 0 raises hs; cycles 1..SW are search window 0..SW-1.
  // sync_at < 0 means no sync byte; stop_at >= 0 truncates the burst.
  task automatic burst(input int sync_at, input int hs_len, input int tail, input int stop_at);
    int          total;
    bit          locked;
    bit          slip;
    int unsigned miss_after;
    bit          err_after;
    exp_t        e;
    logic [7:0]  b;
    total      = hs_len + tail;
    locked     = (sync_at >= 0) && (sync_at < int'(SW)) && (sync_at + 1 < hs_len);
    slip       = !locked && (hs_len >= int'(SW) + 1);
    miss_after = (miss_m < MM) ? miss_m + 1 : MM;
    err_after  = (miss_after >= MM);
    if (stop_at >= 0 && stop_at < total) total = stop_at;
    for (int k = 0; k < total; k++) begin
      b = (sync_at >= 0 && k == sync_at + 1) ? SYNC : rand_nonsync();
      e.bitslip  = slip && (k == int'(SW) + 1);
      e.sync_det = locked && (k == sync_at + 2);
      e.aligned  = locked && (k >= sync_at + 2) && (k <= hs_len);
      e.slip_pos = (slip && k >= int'(SW) + 1) ? 3'(pos_m + 1) : 3'(pos_m);
      if (locked && k >= sync_at + 2)      e.err = 1'b0;
      else if (slip && k >= int'(SW) + 1) e.err = err_after;
      else                                 e.err = err_m;
      drive_cycle(k < hs_len, b, e);
    end
    if (stop_at < 0) begin
      if (locked) begin
        miss_m = 0;
        err_m  = 1'b0;
      end else if (slip) begin
        pos_m  = (pos_m + 1) % 8;
        miss_m = miss_after;
        err_m  = err_after;
      end
    end
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check({tag, "_bitslip"},  8'(bitslip),   8'h00);
    check({tag, "_aligned"},  8'(aligned),   8'h00);
    check({tag, "_sync_det"}, 8'(sync_det),  8'h00);
    check({tag, "_slip_pos"}, 8'(slip_pos),  8'h00);
    check({tag, "_err"},      8'(align_err), 8'h00);
    #1;
    rst_n = 1'b1;
    pos_m  = 0;
    miss_m = 0;
    err_m  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    hs_active = 1'b0;
    lane_byte = 8'h00;
    #23;
    check("rst_bitslip",  8'(bitslip),   8'h00);
    check("rst_aligned",  8'(aligned),   8'h00);
    check("rst_sync_det", 8'(sync_det),  8'h00);
    check("rst_slip_pos", 8'(slip_pos),  8'h00);
    check("rst_err",      8'(align_err), 8'h00);
    rst_n = 1'b1;
    idle(2, 1'b0);

    // Sync at window 5: lock, no slip.
    burst(5, 20, 4, -1);
    // No sync: single slip, hs held high long after.
    burst(-1, 30, 4, -1);
    // Sync on the final window cycle wins over the slip.
    burst(15, 20, 3, -1);
    // Burst aborted at window 3: nothing changes.
    burst(-1, 4, 3, -1);
    // hs drops during SETTLE: settle completes, then back to idle.
    burst(-1, 19, 6, -1);

    // Eight consecutive failures (first ones drop hs during SLIP).
    for (int i = 0; i < 8; i++) burst(-1, 17 + i, 6, -1);
    // Saturated miss count keeps the error raised.
    burst(-1, 18, 6, -1);
    // Successful lock clears the error.
    burst(3, 12, 3, -1);

    // Reset during the SLIP cycle, hs left high: no activity until a new burst.
    burst(-1, 40, 6, 18);
    pulse_reset("rst_slip");
    idle(25, 1'b1);
    idle(2, 1'b0);
    burst(0, 10, 2, -1);

    // Reset while LOCKED, sync bytes still arriving with hs high.
    burst(2, 30, 3, 10);
    pulse_reset("rst_lock");
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, SYNC, idle_exp());
    idle(2, 1'b0);
    burst(-1, 20, 5, -1);
    idle(2, 1'b0);

    @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", 8'(exp_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/dphy_byte_align_ctrl.md
DPHY_BYTE_ALIGN_CTRL -- requirements
Module: dphy_byte_align_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hB8: HS sync byte expected after SoT, compared LSB-first as delivered by the deserializer.
REQ-002 Parameter SEARCH_WINDOW, default 16: byte-clock cycles searched for SYNC_BYTE after HS entry.
REQ-003 Parameter SETTLE_CYCLES, default 3: cycles ignored after each bitslip pulse while the deserializer output settles.
REQ-004 Parameter MAX_MISSES, default 8: consecutive failed bursts before the error flag is raised.
REQ-005 clk_i  input  1  byte clock, the divided lane clock; single clock domain.
REQ-006 rst_n_i  input  1  asynchronous, active-low reset.
REQ-007 hs_active_i  input  1  high while the data lane is in HS mode, from the LP/HS detector.
REQ-008 byte_i  input  8  raw deserialized lane byte.
REQ-009 bitslip_o  output  1  one-cycle pulse to the deserializer bitslip input.
REQ-010 aligned_o  output  1  high from sync detection until HS exit.
REQ-011 sync_det_o  output  1  one-cycle pulse on the cycle after SYNC_BYTE is matched.
REQ-012 slip_pos_o  output  3  current bitslip position, modulo 8.
REQ-013 align_err_o  output  1  high when MAX_MISSES consecutive bursts have failed.

Function
REQ-014 The FSM SHALL have the states IDLE, SEARCH, SLIP, SETTLE, LOCKED and WAIT_LP.
REQ-015 IDLE -> SEARCH on the first cycle with hs_active_i=1, and the window counter SHALL load to 0.
REQ-016 In SEARCH, byte_i==SYNC_BYTE -> LOCKED; sync_det_o and aligned_o SHALL assert on the next cycle; the miss counter SHALL clear; align_err_o SHALL clear.
REQ-017 In SEARCH, no match by window count SEARCH_WINDOW-1 -> SLIP; a match on that last cycle SHALL take priority and go to LOCKED.
REQ-018 SLIP SHALL last one cycle: bitslip_o=1, slip_pos_o increments with wrap 7->0, the miss counter increments and saturates at MAX_MISSES.
REQ-019 SETTLE SHALL count SETTLE_CYCLES cycles with bitslip_o=0, then go to WAIT_LP; consecutive bitslip pulses SHALL be separated by at least SETTLE_CYCLES+1 cycles.
REQ-020 LOCKED SHALL hold aligned_o=1 and go to IDLE when hs_active_i=0; aligned_o SHALL deassert on the cycle after.
REQ-021 WAIT_LP -> IDLE when hs_active_i=0, so each burst gets at most one slip.
REQ-022 hs_active_i falling during SEARCH -> IDLE with no slip and no miss counted.
REQ-023 hs_active_i falling during SLIP or SETTLE SHALL NOT abort the settle; the FSM completes it and then goes through WAIT_LP to IDLE.
REQ-024 align_err_o SHALL set when the miss counter reaches MAX_MISSES and stay set until the next successful lock or reset.
REQ-025 slip_pos_o SHALL be retained across bursts and is changed only by SLIP or reset.
REQ-026 bitslip_o and sync_det_o SHALL be registered outputs.

Reset
REQ-027 rst_n_i=0 SHALL asynchronously force: state IDLE, bitslip_o=0, aligned_o=0, sync_det_o=0, slip_pos_o=0, align_err_o=0, window, settle and miss counters to 0.
REQ-028 Reset asserted mid-SLIP SHALL truncate the bitslip pulse immediately; after release the block waits for a new hs_active_i rising edge, including when hs_active_i is already high.

Structure
REQ-029 The FSM state enum and the default SYNC_BYTE constant SHALL live in the shared csi2_rx package; counter widths SHALL be derived with $clog2 of the parameters.
REQ-030 The block SHALL be a single module with no sub-modules; one instance per data lane, next to that lane's deserializer.

Verification
REQ-031 HS burst with 8'hB8 at window cycle 5 -> sync_det_o pulse at cycle 6, aligned_o=1 until 1 cycle after hs_active_i falls, bitslip_o never asserted.
REQ-032 Burst with no sync byte -> single bitslip_o pulse at cycle 16, slip_pos_o 0->1, next pulse no earlier than 4 cycles later and only in a later burst.
REQ-033 Eight consecutive failing bursts -> slip_pos_o wraps 7->0 and align_err_o=1; a ninth burst with sync present -> align_err_o=0 and aligned_o=1.
REQ-034 Sync byte on window cycle 15 -> lock, no slip; hs_active_i dropping at window cycle 3 -> IDLE, slip_pos_o and miss count unchanged.
REQ-035 rst_n_i pulsed low during SLIP and during LOCKED -> all outputs 0 within the same cycle; no action until the next hs_active_i rising edge.
